// File: rtl/oam_dma.sv
// OAM DMA initiator: snoops CPU writes to the DMA register and copies LENGTH bytes
// from {src_hi,8'h00} into OAM, one byte per CYCLES_PER_BYTE-clock slot.
module oam_dma #(
  parameter int          LENGTH          = 160,
  parameter logic [15:0] DST_BASE        = 16'hFE00,
  parameter logic [15:0] REG_ADDR        = 16'hFF46,
  parameter int          CYCLES_PER_BYTE = 4
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_reg_wr_en,
  input  logic [15:0] i_reg_wr_addr,
  input  logic [7:0]  i_reg_wr_data,
  output logic [7:0]  o_reg_rd_data,
  output logic        o_dma_active,
  output logic [15:0] o_mem_rd_addr,
  input  logic [7:0]  i_mem_rd_data,
  output logic        o_mem_wr_en,
  output logic [15:0] o_mem_wr_addr,
  output logic [7:0]  o_mem_wr_data
);

  localparam int IW = $clog2(LENGTH + 1);
  localparam int PW = (CYCLES_PER_BYTE > 1) ? $clog2(CYCLES_PER_BYTE) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] XFER  = 2'd2;
  localparam logic [1:0] DRAIN = 2'd3;

  logic [1:0]    state;
  logic [7:0]    src_hi;
  logic [IW-1:0] idx;
  logic [PW-1:0] phase;

  logic        trigger;
  logic        last_phase;
  logic        last_idx;
  logic        wr_fire;
  logic [15:0] idx16;

  assign trigger    = i_reg_wr_en && (i_reg_wr_addr == REG_ADDR);
  assign last_phase = (phase == PW'(CYCLES_PER_BYTE - 1));
  assign last_idx   = (idx == IW'(LENGTH - 1));
  assign idx16      = 16'(idx);

  // A trigger restarts the copy from any state, including mid-transfer.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state  <= IDLE;
      src_hi <= 8'hFF;
      idx    <= '0;
      phase  <= '0;
    end else if (trigger) begin
      state  <= START;
      src_hi <= i_reg_wr_data;
      idx    <= '0;
      phase  <= '0;
    end else begin
      case (state)
        START: state <= XFER;
        XFER: begin
          if (last_phase) begin
            phase <= '0;
            if (last_idx) begin
              idx   <= IW'(LENGTH);
              state <= DRAIN;
            end else begin
              idx <= idx + 1'b1;
            end
          end else begin
            phase <= phase + 1'b1;
          end
        end
        DRAIN:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Each slot boundary (and DRAIN) writes byte idx-1, whose read data arrives this cycle.
  assign wr_fire = ((state == XFER) && (phase == '0) && (idx != '0)) || (state == DRAIN);

  assign o_reg_rd_data = src_hi;
  assign o_dma_active  = (state != IDLE);
  assign o_mem_rd_addr = (state == XFER) ? ({src_hi, 8'h00} + idx16) : 16'h0000;
  assign o_mem_wr_en   = wr_fire;
  assign o_mem_wr_addr = wr_fire ? (DST_BASE + idx16 - 16'd1) : 16'h0000;
  assign o_mem_wr_data = wr_fire ? i_mem_rd_data : 8'h00;

endmodule

// File: tb/tb_oam_dma.sv
// Bench for oam_dma: three instances (160x4, 4x1, 256x1) checked every cycle against a
// timeline model derived from the trigger time, plus literal end-of-test expectations.
module tb_oam_dma;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        wen   [3];
  logic [15:0] waddr [3];
  logic [7:0]  wdata [3];
  logic [7:0]  rdback[3];
  logic        act   [3];
  logic [15:0] rda   [3];
  logic [7:0]  rdd   [3];
  logic        mwen  [3];
  logic [15:0] mwa   [3];
  logic [7:0]  mwd   [3];

  logic [7:0] dst [3][256];

  int cmp_n = 0;
  int err_n = 0;
  int act_cnt[3] = '{0, 0, 0};
  int wr_cnt [3] = '{0, 0, 0};

  oam_dma u_a (
    .i_clk(clk), .i_rst(rst),
    .i_reg_wr_en(wen[0]), .i_reg_wr_addr(waddr[0]), .i_reg_wr_data(wdata[0]),
    .o_reg_rd_data(rdback[0]), .o_dma_active(act[0]), .o_mem_rd_addr(rda[0]),
    .i_mem_rd_data(rdd[0]), .o_mem_wr_en(mwen[0]), .o_mem_wr_addr(mwa[0]),
    .o_mem_wr_data(mwd[0])
  );

  oam_dma #(.LENGTH(4), .CYCLES_PER_BYTE(1)) u_b (
    .i_clk(clk), .i_rst(rst),
    .i_reg_wr_en(wen[1]), .i_reg_wr_addr(waddr[1]), .i_reg_wr_data(wdata[1]),
    .o_reg_rd_data(rdback[1]), .o_dma_active(act[1]), .o_mem_rd_addr(rda[1]),
    .i_mem_rd_data(rdd[1]), .o_mem_wr_en(mwen[1]), .o_mem_wr_addr(mwa[1]),
    .o_mem_wr_data(mwd[1])
  );

  oam_dma #(.LENGTH(256), .CYCLES_PER_BYTE(1)) u_c (
    .i_clk(clk), .i_rst(rst),
    .i_reg_wr_en(wen[2]), .i_reg_wr_addr(waddr[2]), .i_reg_wr_data(wdata[2]),
    .o_reg_rd_data(rdback[2]), .o_dma_active(act[2]), .o_mem_rd_addr(rda[2]),
    .i_mem_rd_data(rdd[2]), .o_mem_wr_en(mwen[2]), .o_mem_wr_addr(mwa[2]),
    .o_mem_wr_data(mwd[2])
  );

  function automatic int len_of(int k);
    return (k == 0) ? 160 : (k == 1) ? 4 : 256;
  endfunction

  function automatic int cpb_of(int k);
    return (k == 0) ? 4 : 1;
  endfunction

  // Source memory content; page C0 holds i^0x5A.
  function automatic logic [7:0] pat(logic [15:0] a);
    return (a[7:0] ^ 8'h5A) + (a[15:8] - 8'hC0);
  endfunction

  // Memory with 1-cycle read latency; destination writes captured for the OAM page.
  always @(posedge clk) begin
    for (int k = 0; k < 3; k++) begin
      rdd[k] <= pat(rda[k]);
      if (mwen[k] === 1'b1) dst[k][mwa[k][7:0]] <= mwd[k];
    end
  end

  // Model: time since the last trigger edge; t=0 is the first cycle after it.
  logic       run_m[3] = '{1'b0, 1'b0, 1'b0};
  int         t_m  [3] = '{0, 0, 0};
  logic [7:0] src_m[3] = '{8'hFF, 8'hFF, 8'hFF};

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < 3; k++) begin
        run_m[k] <= 1'b0;
        t_m[k]   <= 0;
        src_m[k] <= 8'hFF;
      end
    end else begin
      for (int k = 0; k < 3; k++) begin
        if (wen[k] && waddr[k] == 16'hFF46) begin
          run_m[k] <= 1'b1;
          t_m[k]   <= 0;
          src_m[k] <= wdata[k];
        end else if (run_m[k]) begin
          if (t_m[k] + 1 >= len_of(k) * cpb_of(k) + 2) run_m[k] <= 1'b0;
          t_m[k] <= t_m[k] + 1;
        end
      end
    end
  end

  task automatic check_cycle(input int k);
    int          tot;
    int          j;
    int          byte_no;
    logic        e_wen;
    logic [15:0] e_ra;
    logic [15:0] e_wa;
    logic [7:0]  e_wd;
    bit          chk_ra;
    bit          chk_w;
    bit          bad;
    tot = len_of(k) * cpb_of(k);
    e_wen = 1'b0; e_ra = 16'h0; e_wa = 16'h0; e_wd = 8'h0;
    chk_ra = 1'b1; chk_w = 1'b1; byte_no = -1;
    if (run_m[k]) begin
      j = t_m[k] - 1;
      if (t_m[k] >= 1 && j < tot) e_ra = {src_m[k], 8'h00} + 16'(j / cpb_of(k));
      else chk_ra = 1'b0;
      if (t_m[k] >= 1 && j == tot) byte_no = len_of(k) - 1;
      else if (t_m[k] >= 1 && j < tot && j > 0 && (j % cpb_of(k)) == 0) byte_no = j / cpb_of(k) - 1;
      if (byte_no >= 0) begin
        e_wen = 1'b1;
        e_wa  = 16'hFE00 + 16'(byte_no);
        e_wd  = pat({src_m[k], 8'h00} + 16'(byte_no));
      end else begin
        chk_w = 1'b0;
      end
    end
    bad = (act[k] !== run_m[k]) || (rdback[k] !== src_m[k]) || (mwen[k] !== e_wen) ||
          (chk_ra && rda[k] !== e_ra) || (chk_w && (mwa[k] !== e_wa || mwd[k] !== e_wd));
    cmp_n++;
    if (bad) begin
      err_n++;
      $display("FAIL cycle inst%0d @%0t: act %b/%b rdback %h/%h rd %h/%h wen %b/%b wa %h/%h wd %h/%h (got/exp)",
               k, $time, act[k], run_m[k], rdback[k], src_m[k], rda[k], e_ra,
               mwen[k], e_wen, mwa[k], e_wa, mwd[k], e_wd);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check_cycle(k);
      if (act[k] === 1'b1) act_cnt[k]++;
      if (mwen[k] === 1'b1) wr_cnt[k]++;
    end
  endtask

  task automatic check_lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic cpu_write(input int k, input logic [15:0] a, input logic [7:0] d);
    wen[k] = 1'b1; waddr[k] = a; wdata[k] = d;
    tick();
    wen[k] = 1'b0; waddr[k] = 16'h0; wdata[k] = 8'h0;
  endtask

  task automatic wait_idle(input int k, input int budget);
    int n;
    n = 0;
    while (act[k] === 1'b1 && n < budget) begin
      tick();
      n++;
    end
    cmp_n++;
    if (act[k] === 1'b1) begin
      err_n++;
      $display("FAIL timeout inst%0d: still active after %0d cycles", k, budget);
    end
  endtask

  initial begin
    int a0;
    int w0;
    int n;
    for (int k = 0; k < 3; k++) begin
      wen[k] = 1'b0; waddr[k] = 16'h0; wdata[k] = 8'h0;
    end
    repeat (3) tick();
    check_lit("reset_readback", 32'(rdback[0]), 32'hFF);
    check_lit("reset_rd_addr", 32'(rda[2]), 32'h0);
    rst = 1'b0;
    repeat (2) tick();

    // Full 160-byte copy from C000.
    a0 = act_cnt[0]; w0 = wr_cnt[0];
    cpu_write(0, 16'hFF46, 8'hC0);
    wait_idle(0, 700);
    check_lit("t1_active_cycles", 32'(act_cnt[0] - a0), 32'd642);
    check_lit("t1_write_count", 32'(wr_cnt[0] - w0), 32'd160);
    check_lit("t1_fe00", 32'(dst[0][0]), 32'h5A);
    check_lit("t1_fe40", 32'(dst[0][64]), 32'h1A);
    check_lit("t1_fe9f", 32'(dst[0][159]), 32'hC5);

    // Short copy, one cycle per byte.
    a0 = act_cnt[1]; w0 = wr_cnt[1];
    cpu_write(1, 16'hFF46, 8'h12);
    wait_idle(1, 20);
    check_lit("t2_active_cycles", 32'(act_cnt[1] - a0), 32'd6);
    check_lit("t2_write_count", 32'(wr_cnt[1] - w0), 32'd4);
    check_lit("t2_fe00", 32'(dst[1][0]), 32'hAC);
    check_lit("t2_fe03", 32'(dst[1][3]), 32'hAB);

    // Restart after 40 writes.
    w0 = wr_cnt[0];
    cpu_write(0, 16'hFF46, 8'hC0);
    n = 0;
    while (wr_cnt[0] - w0 < 40 && n < 400) begin
      tick();
      n++;
    end
    check_lit("t3_writes_before_restart", 32'(wr_cnt[0] - w0), 32'd40);
    cpu_write(0, 16'hFF46, 8'hD0);
    check_lit("t3_readback", 32'(rdback[0]), 32'hD0);
    wait_idle(0, 700);
    check_lit("t3_total_writes", 32'(wr_cnt[0] - w0), 32'd200);
    check_lit("t3_fe00", 32'(dst[0][0]), 32'h6A);
    check_lit("t3_fe9f", 32'(dst[0][159]), 32'hD5);

    // Asynchronous reset in the middle of a transfer.
    cpu_write(0, 16'hFF46, 8'hC0);
    repeat (50) tick();
    #2 rst = 1'b1;
    #1;
    check_lit("t4_active_async", 32'(act[0]), 32'd0);
    check_lit("t4_wr_en_async", 32'(mwen[0]), 32'd0);
    check_lit("t4_readback_async", 32'(rdback[0]), 32'hFF);
    check_lit("t4_rd_addr_async", 32'(rda[0]), 32'h0);
    w0 = wr_cnt[0]; a0 = act_cnt[0];
    repeat (2) tick();
    rst = 1'b0;
    repeat (20) tick();
    check_lit("t4_no_writes_after", 32'(wr_cnt[0] - w0), 32'd0);
    check_lit("t4_no_active_after", 32'(act_cnt[0] - a0), 32'd0);

    // Neighbouring addresses are ignored.
    a0 = act_cnt[0]; w0 = wr_cnt[0];
    cpu_write(0, 16'hFF45, 8'hC0);
    cpu_write(0, 16'hFF47, 8'hC0);
    repeat (10) tick();
    check_lit("t5_no_active", 32'(act_cnt[0] - a0), 32'd0);
    check_lit("t5_no_writes", 32'(wr_cnt[0] - w0), 32'd0);
    check_lit("t5_readback", 32'(rdback[0]), 32'hFF);

    // Source page 0xFF, full 256-byte copy.
    a0 = act_cnt[2]; w0 = wr_cnt[2];
    cpu_write(2, 16'hFF46, 8'hFF);
    wait_idle(2, 300);
    check_lit("t6_active_cycles", 32'(act_cnt[2] - a0), 32'd258);
    check_lit("t6_write_count", 32'(wr_cnt[2] - w0), 32'd256);
    check_lit("t6_fe00", 32'(dst[2][0]), 32'h99);
    check_lit("t6_feff", 32'(dst[2][255]), 32'hE4);
    repeat (3) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end

endmodule
